vproc_mem_bridge: RTL and testbench
===================================

// Module: vproc_mem_bridge
// PURPOSE
// - Sits between vproc_top's memory port and the mmu. vproc_top issues requests without a grant signal.
// - Buffers those requests in an in-order FIFO, relocates each address by ADDR_OFFSET and issues them
//   one at a time to the mmu.
// - Returns every mmu response (rvalid/err/rdata) to vproc_top in request order.
// - Requests outside the mmu window get a local error response and are never issued downstream.
// PARAMETERS
// - MEM_W          32           data width; fixed at 32 in this revision
// - FIFO_DEPTH     4            request FIFO entries; power of two, >=2
// - ADDR_OFFSET    32'h00002000 added to every upstream address before issue
// - WINDOW_SZ      32'h00040000 legal upstream range [0, WINDOW_SZ); checked before the offset is added
// - TIMEOUT_CYCLES 1024         cycles to wait for a downstream response; used only with VPROC_MEM_BRIDGE_TIMEOUT_EN
// PORTS
// - clk_i          in   1      clock
// - rst_ni         in   1      asynchronous reset, active low
// - up_req_i       in   1      request valid from vproc_top; no backpressure
// - up_addr_i      in   32     byte address
// - up_we_i        in   1      write enable
// - up_be_i        in   4      byte enables
// - up_wdata_i     in   MEM_W  write data
// - up_rvalid_o    out  1      response valid (one per request, in order)
// - up_err_o       out  1      response error; valid with up_rvalid_o
// - up_rdata_o     out  MEM_W  read data; valid with up_rvalid_o
// - dn_req_o       out  1      one-cycle request pulse to mmu
// - dn_addr_o      out  32     up_addr + ADDR_OFFSET; held stable until the response
// - dn_we_o        out  1      held stable until the response
// - dn_be_o        out  4      held stable until the response
// - dn_wdata_o     out  MEM_W  held stable until the response
// - dn_rvalid_i    in   1      mmu response valid (one per request, reads and writes)
// - dn_err_i       in   1      mmu error
// - dn_rdata_i     in   MEM_W  mmu read data
// - overflow_o     out  1      sticky: a request arrived while the FIFO was full
// - busy_o         out  1      FIFO non-empty or FSM not IDLE
// BEHAVIOUR
// - Reset: all outputs 0; FIFO empty; FSM=IDLE; timeout counter 0. Reset mid-operation abandons all
//   in-flight and queued requests; no response is produced for them.
// - Push: up_req_i high -> entry {addr, we, be, wdata, oor = addr >= WINDOW_SZ} written at that clock edge.
// - Full: a push is accepted only if a pop happens in the same cycle. Otherwise the request is dropped
//   and overflow_o is set until reset.
// - FSM states:
//   - IDLE: if the FIFO is non-empty, look at the head entry.
//     - head.oor=1: pop it; next cycle up_rvalid_o=1, up_err_o=1, up_rdata_o=0; stay IDLE.
//     - head.oor=0: pop it; register dn_* fields; dn_req_o=1 for exactly the next cycle; go to WAIT.
//   - WAIT: dn_req_o=0.
//     - On dn_rvalid_i: next cycle up_rvalid_o=1 with up_err_o=dn_err_i and up_rdata_o=dn_rdata_i
//       (rdata forced to 0 for writes); go to IDLE.
//     - dn_rvalid_i in the same cycle dn_req_o is high is legal and is accepted.
//   - DRAIN: exists only with VPROC_MEM_BRIDGE_TIMEOUT_EN; see CONFIGURATION.
// - dn_rvalid_i in IDLE is spurious and is ignored.
// - Latency, empty FIFO in IDLE, up_req_i at cycle N:
//   - dn_req_o high in N+1.
//   - If the mmu responds at cycle M (M>=N+1), up_rvalid_o is high in M+1.
//   - Out-of-range request: up_rvalid_o is high in N+2.
// - Back-to-back: at most one downstream request is outstanding. After a response in cycle M, the next
//   dn_req_o is no earlier than M+2.
// - Order: responses leave strictly in push order; local errors never overtake pending mmu responses.
// - up_rvalid_o is a single-cycle pulse per response.
// - dn_addr_o arithmetic: 32-bit add modulo 2^32; the oor check uses the un-offset address.
// CONFIGURATION
// - VPROC_MEM_BRIDGE_TIMEOUT_EN defined:
//   - A 16-bit counter is cleared on WAIT entry and increments each WAIT cycle without dn_rvalid_i.
//   - When it reaches TIMEOUT_CYCLES: next cycle up_rvalid_o=1, up_err_o=1, up_rdata_o=0; go to DRAIN.
//   - DRAIN discards the next dn_rvalid_i, then goes to IDLE; no new request is issued while in DRAIN.
//   - dn_rvalid_i in the same cycle the counter hits TIMEOUT_CYCLES: the response wins and the counter is ignored.
// - Macro undefined: no counter and no DRAIN state; WAIT waits indefinitely.
// TESTING
// - Read 0x100: mmu answers rdata=0xDEADBEEF 3 cycles after dn_req_o -> dn_addr_o=0x2100;
//   up_rvalid_o 1 cycle later with rdata 0xDEADBEEF, err=0.
// - Write 0x40, be=4'b0011, wdata=0x12345678 -> dn_we_o=1, dn_be_o=4'b0011, dn_addr_o=0x2040;
//   response: err=0, rdata=0.
// - Four reads on consecutive cycles (addr 0,4,8,C), mmu latency 2 -> four dn_req_o pulses,
//   responses in order, overflow_o=0.
// - Five reads on consecutive cycles while the mmu is stalled, FIFO_DEPTH=4 -> overflow_o=1 stays set;
//   4 responses total.
// - Read 0x40000 queued behind an in-range read -> in-range response first, then err=1; no dn_req_o
//   for 0x40000.
// - TIMEOUT_EN, TIMEOUT_CYCLES=8, mmu silent, then late rvalid -> err response; late rvalid dropped;
//   the next request proceeds normally.

Source files
------------

// File: rtl/vproc_mem_bridge.sv
// vproc_mem_bridge: in-order request FIFO between vproc_top and the mmu with address relocation
// and local out-of-window errors. Optional response timeout: VPROC_MEM_BRIDGE_TIMEOUT_EN.
module vproc_mem_bridge #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [31:0] ADDR_OFFSET    = 32'h0000_2000,
  parameter logic [31:0] WINDOW_SZ      = 32'h0004_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             up_req_i,
  input  logic [31:0]      up_addr_i,
  input  logic             up_we_i,
  input  logic [3:0]       up_be_i,
  input  logic [MEM_W-1:0] up_wdata_i,
  output logic             up_rvalid_o,
  output logic             up_err_o,
  output logic [MEM_W-1:0] up_rdata_o,
  output logic             dn_req_o,
  output logic [31:0]      dn_addr_o,
  output logic             dn_we_o,
  output logic [3:0]       dn_be_o,
  output logic [MEM_W-1:0] dn_wdata_o,
  input  logic             dn_rvalid_i,
  input  logic             dn_err_i,
  input  logic [MEM_W-1:0] dn_rdata_i,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      addr;
    logic             we;
    logic [3:0]       be;
    logic [MEM_W-1:0] wdata;
    logic             oor;
  } entry_t;

`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_e;
`endif

  entry_t           fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;
  entry_t           in_entry, head, issue_entry;
  logic             push, push_ok, pop, bypass, issue;

  state_e           state_q, state_d;
  logic             up_rvalid_q, up_rvalid_d, up_err_q, up_err_d;
  logic [MEM_W-1:0] up_rdata_q, up_rdata_d;
  logic             dn_req_q, dn_req_d, dn_we_q, dn_we_d;
  logic [31:0]      dn_addr_q, dn_addr_d;
  logic [3:0]       dn_be_q, dn_be_d;
  logic [MEM_W-1:0] dn_wdata_q, dn_wdata_d;
  logic             overflow_q, overflow_d;

  assign in_entry = '{addr: up_addr_i, we: up_we_i, be: up_be_i, wdata: up_wdata_i,
                      oor: (up_addr_i >= WINDOW_SZ)};
  assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // An in-window request arriving at an idle, empty bridge skips the FIFO so dn_req_o
  // rises the very next cycle; out-of-window requests always queue.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    pop         = 1'b0;
    bypass      = 1'b0;
    issue       = 1'b0;
    issue_entry = head;
    up_rvalid_d = 1'b0;
    up_err_d    = 1'b0;
    up_rdata_d  = '0;
    dn_req_d    = 1'b0;
    dn_addr_d   = dn_addr_q;
    dn_we_d     = dn_we_q;
    dn_be_d     = dn_be_q;
    dn_wdata_d  = dn_wdata_q;
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.oor) begin
            up_rvalid_d = 1'b1;
            up_err_d    = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end else if (up_req_i && !in_entry.oor) begin
          bypass      = 1'b1;
          issue       = 1'b1;
          issue_entry = in_entry;
        end
      end
      WAIT: begin
        if (dn_rvalid_i) begin
          up_rvalid_d = 1'b1;
          up_err_d    = dn_err_i;
          up_rdata_d  = dn_we_q ? '0 : dn_rdata_i;
          state_d     = IDLE;
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
        end else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          up_rvalid_d = 1'b1;
          up_err_d    = 1'b1;
          state_d     = DRAIN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        end
      end
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
      DRAIN: begin
        if (dn_rvalid_i) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d    = WAIT;
      dn_req_d   = 1'b1;
      dn_addr_d  = issue_entry.addr + ADDR_OFFSET;
      dn_we_d    = issue_entry.we;
      dn_be_d    = issue_entry.be;
      dn_wdata_d = issue_entry.wdata;
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
      tmo_cnt_d  = '0;
`endif
    end
  end

  assign push       = up_req_i && !bypass;
  assign push_ok    = push && (!fifo_full || pop);
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);
  assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push_ok};
  assign rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};

  // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      up_rvalid_q <= 1'b0;
      up_err_q    <= 1'b0;
      up_rdata_q  <= '0;
      dn_req_q    <= 1'b0;
      dn_addr_q   <= '0;
      dn_we_q     <= 1'b0;
      dn_be_q     <= '0;
      dn_wdata_q  <= '0;
      overflow_q  <= 1'b0;
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      up_rvalid_q <= up_rvalid_d;
      up_err_q    <= up_err_d;
      up_rdata_q  <= up_rdata_d;
      dn_req_q    <= dn_req_d;
      dn_addr_q   <= dn_addr_d;
      dn_we_q     <= dn_we_d;
      dn_be_q     <= dn_be_d;
      dn_wdata_q  <= dn_wdata_d;
      overflow_q  <= overflow_d;
`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign up_rvalid_o = up_rvalid_q;
  assign up_err_o    = up_err_q;
  assign up_rdata_o  = up_rdata_q;
  assign dn_req_o    = dn_req_q;
  assign dn_addr_o   = dn_addr_q;
  assign dn_we_o     = dn_we_q;
  assign dn_be_o     = dn_be_q;
  assign dn_wdata_o  = dn_wdata_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_vproc_mem_bridge.sv
// Scoreboard bench for vproc_mem_bridge: stimulus queues expected downstream requests and
// upstream responses; monitors and an mmu model compare them as the DUT produces them.
module tb_vproc_mem_bridge;

`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 1024;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dn_exp_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } mmu_rsp_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } up_exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        up_req_i = 1'b0;
  logic [31:0] up_addr_i = '0;
  logic        up_we_i = 1'b0;
  logic [3:0]  up_be_i = '0;
  logic [31:0] up_wdata_i = '0;
  logic        up_rvalid_o, up_err_o;
  logic [31:0] up_rdata_o;
  logic        dn_req_o, dn_we_o;
  logic [31:0] dn_addr_o, dn_wdata_o;
  logic [3:0]  dn_be_o;
  logic        dn_rvalid_i = 1'b0;
  logic        dn_err_i = 1'b0;
  logic [31:0] dn_rdata_i = '0;
  logic        overflow_o, busy_o;

  dn_exp_t  exp_dn_q[$];
  mmu_rsp_t mmu_q[$];
  up_exp_t  exp_up_q[$];
  int       checks = 0;
  int       errors = 0;
  int       dn_cnt = 0;
  logic     spurious_req = 1'b0;

  vproc_mem_bridge #(
    .MEM_W(32), .FIFO_DEPTH(4), .ADDR_OFFSET(32'h0000_2000),
    .WINDOW_SZ(32'h0004_0000), .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .up_req_i(up_req_i), .up_addr_i(up_addr_i), .up_we_i(up_we_i),
    .up_be_i(up_be_i), .up_wdata_i(up_wdata_i),
    .up_rvalid_o(up_rvalid_o), .up_err_o(up_err_o), .up_rdata_o(up_rdata_o),
    .dn_req_o(dn_req_o), .dn_addr_o(dn_addr_o), .dn_we_o(dn_we_o),
    .dn_be_o(dn_be_o), .dn_wdata_o(dn_wdata_o),
    .dn_rvalid_i(dn_rvalid_i), .dn_err_i(dn_err_i), .dn_rdata_i(dn_rdata_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata);
    up_req_i   = 1'b1;
    up_addr_i  = addr;
    up_we_i    = we;
    up_be_i    = be;
    up_wdata_i = wdata;
    tick();
    up_req_i   = 1'b0;
  endtask

  // In-window access: expected mmu request, mmu behaviour and upstream response are queued.
  task automatic exp_access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input int lat, input logic err,
                            input logic [31:0] mmu_rdata, input logic [31:0] up_rdata);
    exp_dn_q.push_back('{addr: addr + 32'h2000, we: we, be: be, wdata: wdata});
    mmu_q.push_back('{lat: lat, err: err, rdata: mmu_rdata});
    exp_up_q.push_back('{err: err, rdata: up_rdata});
    send(addr, we, be, wdata);
  endtask

  task automatic exp_read(input logic [31:0] addr, input int lat, input logic err,
                          input logic [31:0] rdata);
    exp_access(addr, 1'b0, 4'hF, 32'h0, lat, err, rdata, rdata);
  endtask

  task automatic exp_oor(input logic [31:0] addr);
    exp_up_q.push_back('{err: 1'b1, rdata: 32'h0});
    send(addr, 1'b0, 4'hF, 32'h0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((exp_up_q.size() != 0 || busy_o) && n < max) begin
      tick();
      n++;
    end
    check("drain_in_budget", 32'(n < max), 32'd1);
    repeat (2) tick();
  endtask

  // Upstream response monitor.
  initial begin : up_mon
    up_exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && up_rvalid_o) begin
        if (exp_up_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_up_q.pop_front();
          check("rsp_err", 32'(up_err_o), 32'(e.err));
          check("rsp_rdata", up_rdata_o, e.rdata);
        end
      end
    end
  end

  // Downstream request monitor.
  initial begin : dn_mon
    dn_exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && dn_req_o) begin
        dn_cnt++;
        if (exp_dn_q.size() == 0) begin
          check("dn_unexpected", dn_addr_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_dn_q.pop_front();
          check("dn_addr", dn_addr_o, e.addr);
          check("dn_we", 32'(dn_we_o), 32'(e.we));
          check("dn_be", 32'(dn_be_o), 32'(e.be));
          check("dn_wdata", dn_wdata_o, e.wdata);
        end
      end
    end
  end

  // mmu model: answers each request after its queued latency (0 = same cycle as dn_req_o).
  initial begin : mmu
    mmu_rsp_t    m;
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      if (spurious_req) begin
        dn_rvalid_i = 1'b1;
        dn_err_i    = 1'b1;
        dn_rdata_i  = 32'hCAFE_F00D;
        tick();
        dn_rvalid_i = 1'b0;
        dn_err_i    = 1'b0;
        dn_rdata_i  = '0;
      end else if (rst_ni && dn_req_o) begin
        if (mmu_q.size() == 0) begin
          check("mmu_unexpected_req", dn_addr_o, 32'hFFFF_FFFF);
        end else begin
          m = mmu_q.pop_front();
          a = dn_addr_o;
          if (m.lat > 0) begin
            repeat (m.lat) @(posedge clk_i);
            #1;
          end
          dn_rvalid_i = 1'b1;
          dn_err_i    = m.err;
          dn_rdata_i  = m.rdata;
          check("dn_addr_held", dn_addr_o, a);
          tick();
          dn_rvalid_i = 1'b0;
          dn_err_i    = 1'b0;
          dn_rdata_i  = '0;
        end
      end
    end
  end

  initial begin : stim
    int base;
    repeat (3) tick();
    @(negedge clk_i);
    check("rst_up_rvalid", 32'(up_rvalid_o), 32'd0);
    check("rst_dn_req", 32'(dn_req_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_dn_addr", dn_addr_o, 32'd0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // Read 0x100, mmu answers 3 cycles after dn_req_o; dn_req_o must rise the next cycle.
    exp_read(32'h100, 3, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("lat_dn_req_next_cycle", 32'(dn_req_o), 32'd1);
    wait_idle(50);

    // Write: returned rdata is forced to zero whatever the mmu drives.
    exp_access(32'h40, 1'b1, 4'b0011, 32'h1234_5678, 1, 1'b0, 32'hAAAA_5555, 32'h0);
    wait_idle(50);

    // Four back-to-back reads, mmu latency 2, plus an mmu error and a same-cycle response.
    base = dn_cnt;
    for (int i = 0; i < 4; i++) exp_read(32'(i * 4), 2, 1'b0, 32'h1000 + 32'(i));
    wait_idle(100);
    check("four_reads_dn_pulses", 32'(dn_cnt - base), 32'd4);
    check("four_reads_no_overflow", 32'(overflow_o), 32'd0);
    exp_read(32'h600, 1, 1'b1, 32'hBAD0_BAD0);
    exp_read(32'h500, 0, 1'b0, 32'h0000_0055);
    exp_read(32'h3_FFFC, 1, 1'b0, 32'h0003_FFFC);
    wait_idle(100);

    // A response while idle must be ignored.
    spurious_req = 1'b1;
    @(negedge clk_i);
    spurious_req = 1'b0;
    repeat (4) tick();
    check("spurious_busy", 32'(busy_o), 32'd0);

    // Lone out-of-window request: local error two cycles after the request.
    exp_oor(32'h0004_0000);
    @(negedge clk_i);
    check("oor_not_early", 32'(up_rvalid_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("oor_lat_n2", 32'(up_rvalid_o), 32'd1);
    wait_idle(50);

    // Out-of-window read queued behind an in-window one: ordered, never issued downstream.
    base = dn_cnt;
    exp_read(32'h300, 4, 1'b0, 32'h3030_3030);
    exp_oor(32'h0004_0000);
    exp_oor(32'hFFFF_F000);
    wait_idle(100);
    check("oor_dn_pulses", 32'(dn_cnt - base), 32'd1);

    // Stalled mmu: blocker plus five reads; the fifth is dropped and overflow sticks.
    exp_read(32'h200, 30, 1'b0, 32'h2222_0000);
    for (int i = 0; i < 4; i++) exp_read(32'h210 + 32'(i * 4), 1, 1'b0, 32'h2222_0001 + 32'(i));
    send(32'h220, 1'b0, 4'hF, 32'h0);
    @(negedge clk_i);
    check("overflow_set", 32'(overflow_o), 32'd1);
    wait_idle(200);
    check("overflow_sticky", 32'(overflow_o), 32'd1);

`ifdef VPROC_MEM_BRIDGE_TIMEOUT_EN
    // Silent mmu: timeout error, late response dropped, next request normal.
    exp_dn_q.push_back('{addr: 32'h2700, we: 1'b0, be: 4'hF, wdata: 32'h0});
    mmu_q.push_back('{lat: 20, err: 1'b0, rdata: 32'h7777_7777});
    exp_up_q.push_back('{err: 1'b1, rdata: 32'h0});
    send(32'h700, 1'b0, 4'hF, 32'h0);
    wait_idle(100);
    exp_read(32'h704, 1, 1'b0, 32'h7070_7070);
    wait_idle(50);
`endif

    check("exp_dn_empty", 32'(exp_dn_q.size()), 32'd0);
    check("mmu_q_empty", 32'(mmu_q.size()), 32'd0);
    check("exp_up_empty", 32'(exp_up_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
